// File: rtl/ps2_key_tx_pkg.sv
// Shared definitions for the PS/2 keypad transmitter and the receive-side
// decoder: the frame state encoding, the break prefix and the hex-to-make-code
// table.
package ps2_key_tx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BIT_HI = 2'd1,
      BIT_LO = 2'd2,
      GAP    = 2'd3
   } ps2_state_t;

   localparam logic [7:0] BREAK_PREFIX = 8'hF0;

   // Set-2 make code for each hex keypad digit.
   function automatic logic [7:0] hex_to_scancode(input logic [3:0] digit);
      logic [7:0] code;
      case (digit)
         4'h0:    code = 8'h45;
         4'h1:    code = 8'h16;
         4'h2:    code = 8'h1E;
         4'h3:    code = 8'h26;
         4'h4:    code = 8'h25;
         4'h5:    code = 8'h2E;
         4'h6:    code = 8'h36;
         4'h7:    code = 8'h3D;
         4'h8:    code = 8'h3E;
         4'h9:    code = 8'h46;
         4'hA:    code = 8'h1C;
         4'hB:    code = 8'h32;
         4'hC:    code = 8'h21;
         4'hD:    code = 8'h23;
         4'hE:    code = 8'h24;
         default: code = 8'h2B;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/ps2_key_tx_if.sv
// Request/response and PS/2 line signals between a keypad source and the
// PS/2 keystroke transmitter.
interface ps2_key_tx_if;

   logic [3:0] num;
   logic       valid;
   logic       ready;
   logic       done;
   logic       ps2_clk;
   logic       ps2_data;

   modport master (
      output num, valid,
      input  ready, done, ps2_clk, ps2_data
   );

   modport slave (
      input  num, valid,
      output ready, done, ps2_clk, ps2_data
   );

endinterface

// File: rtl/ps2_frame_tx.sv
// Serialises one byte as an 11-bit PS/2 device frame (start, 8 data bits LSB
// first, odd parity, stop) followed by an idle gap. frame_done is high during
// the final gap cycle; a start seen in that cycle chains the next frame with
// no idle bubble.
module ps2_frame_tx
   import ps2_key_tx_pkg::*;
#(
   parameter int HALF_PERIOD = 2500,
   parameter int GAP_CYCLES  = 5000
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       busy,
   output logic       frame_done,
   output logic       ps2_clk,
   output logic       ps2_data
);

   localparam int TMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX);

   localparam logic [TW-1:0] HALF_LAST = TW'(HALF_PERIOD - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

   ps2_state_t  state;
   logic [TW-1:0] timer;
   logic [3:0]  bit_idx;
   logic [10:0] frame_bits;
   logic        load;

   assign busy       = (state != IDLE);
   assign frame_done = (state == GAP) && (timer == GAP_LAST);
   assign load       = start && ((state == IDLE) || frame_done);

   // Frame sequencer: times each half period and the gap, shifts out the
   // frame bits and keeps the PS/2 lines registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         timer      <= '0;
         bit_idx    <= '0;
         frame_bits <= '1;
         ps2_clk    <= 1'b1;
         ps2_data   <= 1'b1;
      end else if (load) begin
         state      <= BIT_HI;
         timer      <= '0;
         bit_idx    <= '0;
         frame_bits <= {1'b1, ~^byte_in, byte_in, 1'b0};
         ps2_clk    <= 1'b1;
         ps2_data   <= 1'b0;
      end else begin
         case (state)
            BIT_HI: begin
               if (timer == HALF_LAST) begin
                  timer   <= '0;
                  state   <= BIT_LO;
                  ps2_clk <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            BIT_LO: begin
               if (timer == HALF_LAST) begin
                  timer   <= '0;
                  ps2_clk <= 1'b1;
                  if (bit_idx < 4'd10) begin
                     bit_idx    <= bit_idx + 4'd1;
                     frame_bits <= {1'b1, frame_bits[10:1]};
                     ps2_data   <= frame_bits[1];
                     state      <= BIT_HI;
                  end else begin
                     ps2_data <= 1'b1;
                     state    <= GAP;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            GAP: begin
               if (timer == GAP_LAST) begin
                  timer <= '0;
                  state <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_tx.sv
// PS/2 keyboard emulator for the hex keypad: a single accepted digit is sent
// as make code, break prefix, make code over three back-to-back frames, with
// a one-cycle done pulse when the last frame's gap ends.
module ps2_key_tx
   import ps2_key_tx_pkg::*;
#(
   parameter int HALF_PERIOD = 2500,
   parameter int GAP_CYCLES  = 5000
)
(
   input logic         clk,
   input logic         rst_n,
   ps2_key_tx_if.slave bus
);

   logic       ready_q;
   logic       done_q;
   logic [1:0] byte_idx;
   logic [7:0] make_code;
   logic       accept;
   logic       f_start;
   logic [7:0] f_byte;
   logic       f_busy;
   logic       f_done;
   logic       f_clk;
   logic       f_data;

   assign accept  = bus.valid && ready_q && !f_busy;
   assign f_start = accept || (f_done && (byte_idx != 2'd2));
   assign f_byte  = accept              ? hex_to_scancode(bus.num) :
                    (byte_idx == 2'd0)  ? BREAK_PREFIX : make_code;

   assign bus.ready    = ready_q;
   assign bus.done     = done_q;
   assign bus.ps2_clk  = f_clk;
   assign bus.ps2_data = f_data;

   // Keystroke sequencer: latches the digit's make code on accept and steps
   // through the three bytes as each frame finishes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         byte_idx  <= '0;
         make_code <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            ready_q   <= 1'b0;
            byte_idx  <= '0;
            make_code <= hex_to_scancode(bus.num);
         end else if (f_done) begin
            if (byte_idx == 2'd2) begin
               done_q  <= 1'b1;
               ready_q <= 1'b1;
            end else begin
               byte_idx <= byte_idx + 2'd1;
            end
         end
      end
   end

   ps2_frame_tx #(
      .HALF_PERIOD (HALF_PERIOD),
      .GAP_CYCLES  (GAP_CYCLES)
   ) u_frame (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (f_start),
      .byte_in    (f_byte),
      .busy       (f_busy),
      .frame_done (f_done),
      .ps2_clk    (f_clk),
      .ps2_data   (f_data)
   );

endmodule
